// File: rtl/trap_shaper_pkg.sv
// Shared defaults, internal-width helper and peak-detector state type for trap_shaper.
// The peak detector is built only when TRAP_SHAPER_PEAK_DETECT_EN is defined.
package trap_shaper_pkg;

  localparam int ADC_W_DEF     = 12;
  localparam int OUT_W_DEF     = 16;
  localparam int MAX_DEPTH_DEF = 32;
  localparam int M_W_DEF       = 6;

  // Worst-case growth: sample + gain + two integrators bounded by the delay depth.
  function automatic int int_w(input int adc_w, input int m_w, input int max_depth);
    return adc_w + m_w + $clog2(max_depth + 1) + 4;
  endfunction

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    REPORT = 2'd2
  } peak_state_t;

endpackage

// File: rtl/trap_delay_line.sv
// Valid-gated sample history with synchronous clear; exposes x[n-k], x[n-l], x[n-k-l].
module trap_delay_line #(
  parameter int W     = 12,
  parameter int DEPTH = 32,
  parameter int D_W   = 6
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clr,
  input  logic           shift,
  input  logic [W-1:0]   din,
  input  logic [D_W-1:0] k,
  input  logic [D_W-1:0] l,
  input  logic [D_W-1:0] kl,
  output logic [W-1:0]   tap_k,
  output logic [W-1:0]   tap_l,
  output logic [W-1:0]   tap_kl
);

  // mem[i] holds the sample accepted i shifts ago, relative to the one on din.
  logic [W-1:0] mem [1:DEPTH];

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      for (int i = 1; i <= DEPTH; i++) mem[i] <= '0;
    end else if (shift) begin
      mem[1] <= din;
      for (int i = 2; i <= DEPTH; i++) mem[i] <= mem[i-1];
    end
  end

  always_comb begin
    tap_k  = '0;
    tap_l  = '0;
    tap_kl = '0;
    for (int i = 1; i <= DEPTH; i++) begin
      if (k  == D_W'(i)) tap_k  = mem[i];
      if (l  == D_W'(i)) tap_l  = mem[i];
      if (kl == D_W'(i)) tap_kl = mem[i];
    end
  end

endmodule

// File: rtl/trap_shaper.sv
// Trapezoidal shaper with pole-zero gain, saturating output and a config flush.
// Define TRAP_SHAPER_PEAK_DETECT_EN to build the peak FSM and its handshake ports.
module trap_shaper
  import trap_shaper_pkg::*;
#(
  parameter int ADC_W     = ADC_W_DEF,
  parameter int OUT_W     = OUT_W_DEF,
  parameter int MAX_DEPTH = MAX_DEPTH_DEF,
  parameter int M_W       = M_W_DEF,
  localparam int D_W      = $clog2(MAX_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [ADC_W-1:0] in_data,
  input  logic [D_W-1:0]   cfg_k,
  input  logic [D_W-1:0]   cfg_l,
  input  logic [M_W-1:0]   cfg_m,
  input  logic [OUT_W-1:0] cfg_thr,
  input  logic             cfg_load,
  output logic             cfg_busy,
  output logic             cfg_err,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat
`ifdef TRAP_SHAPER_PEAK_DETECT_EN
  ,
  output logic             peak_valid,
  output logic [OUT_W-1:0] peak_data,
  input  logic             peak_ready,
  output logic             peak_lost,
  output peak_state_t      peak_state
`endif
);

  localparam int IW = int_w(ADC_W, M_W, MAX_DEPTH);
  localparam logic signed [IW-1:0] OUT_MAX = $signed({{(IW-OUT_W){1'b0}}, {OUT_W{1'b1}}});

  // Handshake: a sample is taken when in_valid=1, no flush is running and no
  // cfg_load is presented in the same cycle; there is no backpressure.
  logic [D_W-1:0] k_q, l_q, kl_q;
  logic [M_W-1:0] m_q;
  logic [D_W-1:0] flush_cnt;
  logic [D_W:0]   kl_sum;
  logic           cfg_legal, load_acc, load_ok, load_bad, take;

  assign kl_sum    = {1'b0, cfg_k} + {1'b0, cfg_l};
  assign cfg_legal = (cfg_k != '0) && (cfg_k <= cfg_l) && (kl_sum <= (D_W+1)'(MAX_DEPTH));
  assign load_acc  = cfg_load && !cfg_busy;
  assign load_ok   = load_acc && cfg_legal;
  assign load_bad  = load_acc && !cfg_legal;
  assign take      = in_valid && !cfg_busy && !cfg_load;
  assign kl_q      = k_q + l_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      k_q       <= D_W'(1);
      l_q       <= D_W'(1);
      m_q       <= '0;
      cfg_busy  <= 1'b0;
      cfg_err   <= 1'b0;
      flush_cnt <= '0;
    end else begin
      cfg_err <= load_bad;
      if (load_ok) begin
        k_q       <= cfg_k;
        l_q       <= cfg_l;
        m_q       <= cfg_m;
        cfg_busy  <= 1'b1;
        flush_cnt <= D_W'(MAX_DEPTH);
      end else if (cfg_busy) begin
        if (flush_cnt == '0) cfg_busy <= 1'b0;
        else flush_cnt <= flush_cnt - 1'b1;
      end
    end
  end

  logic [ADC_W-1:0] tap_k, tap_l, tap_kl;

  trap_delay_line #(
    .W     (ADC_W),
    .DEPTH (MAX_DEPTH),
    .D_W   (D_W)
  ) u_delay (
    .clk    (clk),
    .reset  (reset),
    .clr    (cfg_busy),
    .shift  (take),
    .din    (in_data),
    .k      (k_q),
    .l      (l_q),
    .kl     (kl_q),
    .tap_k  (tap_k),
    .tap_l  (tap_l),
    .tap_kl (tap_kl)
  );

  logic signed [IW-1:0] x_e, tk_e, tl_e, tkl_e, d_c, m_e;
  logic signed [IW-1:0] d1, d2, p_acc, r3, s_acc, s_next;
  logic                 v1, v2, v3;

  assign x_e    = $signed({{(IW-ADC_W){1'b0}}, in_data});
  assign tk_e   = $signed({{(IW-ADC_W){1'b0}}, tap_k});
  assign tl_e   = $signed({{(IW-ADC_W){1'b0}}, tap_l});
  assign tkl_e  = $signed({{(IW-ADC_W){1'b0}}, tap_kl});
  assign m_e    = $signed({{(IW-M_W){1'b0}}, m_q});
  assign d_c    = x_e - tk_e - tl_e + tkl_e;
  assign s_next = s_acc + r3;

  // Four register stages: difference, first integrator, gain, second integrator + clamp.
  always_ff @(posedge clk) begin
    if (!reset || load_ok || cfg_busy) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      out_valid <= 1'b0;
      d1        <= '0;
      d2        <= '0;
      p_acc     <= '0;
      r3        <= '0;
      s_acc     <= '0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      v1 <= take;
      if (take) d1 <= d_c;
      v2 <= v1;
      if (v1) begin
        p_acc <= p_acc + d1;
        d2    <= d1;
      end
      v3 <= v2;
      if (v2) r3 <= p_acc + m_e * d2;
      out_valid <= v3;
      if (v3) begin
        s_acc <= s_next;
        if (s_next > OUT_MAX) begin
          out_data <= {OUT_W{1'b1}};
          out_sat  <= 1'b1;
        end else if (s_next < 0) begin
          out_data <= '0;
          out_sat  <= 1'b1;
        end else begin
          out_data <= s_next[OUT_W-1:0];
          out_sat  <= 1'b0;
        end
      end else begin
        out_data <= '0;
        out_sat  <= 1'b0;
      end
    end
  end

`ifdef TRAP_SHAPER_PEAK_DETECT_EN
  logic [OUT_W-1:0] thr_q, peak_max;
  logic             above, above_prev;

  assign above = out_data >= thr_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      thr_q      <= {OUT_W{1'b1}};
      peak_state <= IDLE;
      peak_max   <= '0;
      peak_data  <= '0;
      peak_valid <= 1'b0;
      peak_lost  <= 1'b0;
      above_prev <= 1'b0;
    end else if (load_ok) begin
      thr_q      <= cfg_thr;
      peak_state <= IDLE;
      peak_max   <= '0;
      peak_data  <= '0;
      peak_valid <= 1'b0;
      peak_lost  <= 1'b0;
      above_prev <= 1'b0;
    end else begin
      peak_lost <= 1'b0;
      if (out_valid) above_prev <= above;
      case (peak_state)
        IDLE: if (out_valid && above) begin
          peak_state <= TRACK;
          peak_max   <= out_data;
        end
        TRACK: if (out_valid) begin
          if (above) begin
            if (out_data > peak_max) peak_max <= out_data;
          end else begin
            peak_state <= REPORT;
            peak_data  <= peak_max;
            peak_valid <= 1'b1;
          end
        end
        REPORT: begin
          // A fresh rising crossing cannot be tracked while a report is pending.
          if (out_valid && above && !above_prev) peak_lost <= 1'b1;
          if (peak_ready) begin
            peak_state <= IDLE;
            peak_valid <= 1'b0;
          end
        end
        default: peak_state <= IDLE;
      endcase
    end
  end
`else
  logic unused_thr;
  assign unused_thr = ^cfg_thr;
`endif

endmodule

// File: tb/tb_trap_shaper.sv
// Directed bench for trap_shaper: sample-level reference model plus literal pins.
module tb_trap_shaper;

  localparam int ADC_W     = 12;
  localparam int OUT_W     = 16;
  localparam int MAX_DEPTH = 32;
  localparam int M_W       = 6;
  localparam int D_W       = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset, in_valid, cfg_load;
  logic [ADC_W-1:0] in_data;
  logic [D_W-1:0]   cfg_k, cfg_l;
  logic [M_W-1:0]   cfg_m;
  logic [OUT_W-1:0] cfg_thr;
  logic             cfg_busy, cfg_err, out_valid, out_sat;
  logic [OUT_W-1:0] out_data;
`ifdef TRAP_SHAPER_PEAK_DETECT_EN
  logic             peak_valid, peak_ready, peak_lost;
  logic [OUT_W-1:0] peak_data;
  trap_shaper_pkg::peak_state_t peak_state;
  int               lost_cnt;
`endif

  trap_shaper dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .cfg_k      (cfg_k),
    .cfg_l      (cfg_l),
    .cfg_m      (cfg_m),
    .cfg_thr    (cfg_thr),
    .cfg_load   (cfg_load),
    .cfg_busy   (cfg_busy),
    .cfg_err    (cfg_err),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_sat    (out_sat)
`ifdef TRAP_SHAPER_PEAK_DETECT_EN
    ,
    .peak_valid (peak_valid),
    .peak_data  (peak_data),
    .peak_ready (peak_ready),
    .peak_lost  (peak_lost),
    .peak_state (peak_state)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: history of accepted samples since the last flush/reset.
  int              hist[$];
  longint          mp, ms;
  int              mk, ml, mm;
  int              exp_cyc[$];
  logic [OUT_W:0]  exp_q[$];
  logic [OUT_W:0]  got_q[$];
  int              cyc = 0;
  int              busy_lo = -1, busy_hi = -2, err_cyc = -1;
  bit              armed = 0;
  bit              ev, busy_m;

  function automatic longint hx(input int i);
    if (i < 0) return 0;
    return hist[i];
  endfunction

  function automatic bit legal(input int k, input int l);
    return (k >= 1) && (k <= l) && (k + l <= MAX_DEPTH);
  endfunction

  task automatic model_step(input int x, input int due);
    longint d, r;
    int n;
    hist.push_back(x);
    n = hist.size() - 1;
    d = hx(n) - hx(n - mk) - hx(n - ml) + hx(n - mk - ml);
    mp += d;
    r = mp + longint'(mm) * d;
    ms += r;
    exp_cyc.push_back(due);
    if (ms > 65535)  exp_q.push_back({1'b1, 16'hffff});
    else if (ms < 0) exp_q.push_back({1'b1, 16'h0000});
    else             exp_q.push_back({1'b0, ms[15:0]});
  endtask

  always @(negedge clk) begin
    if (armed) begin
      ev = (exp_cyc.size() > 0) && (exp_cyc[0] == cyc);
      check("out_valid", out_valid, ev);
      if (ev) begin
        check("out_word", {out_sat, out_data}, exp_q[0]);
        void'(exp_cyc.pop_front());
        void'(exp_q.pop_front());
      end
      check("cfg_busy", cfg_busy, (cyc >= busy_lo) && (cyc <= busy_hi));
      check("cfg_err", cfg_err, cyc == err_cyc);
      if (out_valid) got_q.push_back({out_sat, out_data});
`ifdef TRAP_SHAPER_PEAK_DETECT_EN
      if (peak_lost) lost_cnt++;
`endif
    end
    if (reset === 1'b0) begin
      armed = 1;
      mk = 1; ml = 1; mm = 0;
      hist.delete(); mp = 0; ms = 0;
      exp_cyc.delete(); exp_q.delete();
      busy_lo = -1; busy_hi = -2; err_cyc = -1;
    end else if (armed) begin
      busy_m = (cyc >= busy_lo) && (cyc <= busy_hi);
      if (cfg_load && !busy_m) begin
        if (legal(cfg_k, cfg_l)) begin
          mk = cfg_k; ml = cfg_l; mm = cfg_m;
          hist.delete(); mp = 0; ms = 0;
          exp_cyc.delete(); exp_q.delete();
          busy_lo = cyc + 1; busy_hi = cyc + MAX_DEPTH + 1;
        end else begin
          err_cyc = cyc + 1;
        end
      end else if (in_valid && !busy_m) begin
        model_step(in_data, cyc + 4);
      end
    end
    cyc++;
  end

  task automatic drive(input bit v, input int x, input bit ld = 0);
    in_valid = v;
    in_data  = ADC_W'(x);
    cfg_load = ld;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cfg_load = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0);
  endtask

  task automatic load(input int k, input int l, input int m, input int thr,
                      input bit v = 0, input int x = 0);
    cfg_k = D_W'(k); cfg_l = D_W'(l); cfg_m = M_W'(m); cfg_thr = OUT_W'(thr);
    drive(v, x, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      if (!cfg_busy) break;
      drive(0, 0, 0);
    end
    check("flush_done", cfg_busy, 0);
  endtask

  int lat, cnt;
  int pulse_a[6] = '{0, 60, 120, 80, 10, 10};
  int pulse_b[3] = '{70, 90, 20};

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_data = '0; cfg_load = 1'b0;
    cfg_k = 1; cfg_l = 1; cfg_m = 0; cfg_thr = '1;
`ifdef TRAP_SHAPER_PEAK_DETECT_EN
    peak_ready = 1'b0; lost_cnt = 0;
`endif
    repeat (3) drive(0, 0, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_sat", out_sat, 0);
    check("rst_busy", cfg_busy, 0);
    check("rst_err", cfg_err, 0);
    reset = 1'b1;
    idle(2);

    // Ramp to plateau with k=2, l=4, M=0.
    load(2, 4, 0, 200);
    wait_idle();
    got_q.delete();
    lat = -1;
    for (int i = 0; i < 12; i++) begin
      drive(1, 100);
      if (lat < 0 && out_valid) lat = i + 1;
    end
    idle(8);
    check("latency", lat, 4);
    check("ramp_count", got_q.size(), 12);
    if (got_q.size() >= 6) begin
      check("ramp0", got_q[0], 100);
      check("ramp1", got_q[1], 300);
      check("ramp2", got_q[2], 500);
      check("ramp3", got_q[3], 700);
      check("ramp4", got_q[4], 800);
      check("ramp5", got_q[5], 800);
    end

    // Illegal config is rejected; stream keeps running on the old config.
    for (int i = 0; i < 3; i++) drive(1, 50);
    cfg_k = 5; cfg_l = 3;
    drive(0, 0, 1);
    check("err_pulse", cfg_err, 1);
    check("err_no_busy", cfg_busy, 0);
    drive(1, 50);
    check("err_once", cfg_err, 0);
    for (int i = 0; i < 5; i++) drive(1, $urandom_range(0, 4095));
    idle(6);

    // Load wins over a coincident sample; samples during the flush vanish.
    load(2, 4, 0, 200, 1, 77);
    cnt = 0;
    while (cfg_busy && cnt < 60) begin
      drive(1, 55);
      cnt++;
    end
    check("busy_len", cnt, 33);
    got_q.delete();
    drive(1, 100);
    idle(6);
    check("restart_count", got_q.size(), 1);
    if (got_q.size() >= 1) check("restart0", got_q[0], 100);

    // Full-scale step with maximum gain saturates both ways.
    load(1, 1, 63, 200);
    wait_idle();
    got_q.delete();
    for (int i = 0; i < 4; i++) drive(1, 4095);
    for (int i = 0; i < 2; i++) drive(1, 0);
    idle(6);
    check("sat_count", got_q.size(), 6);
    if (got_q.size() >= 6) begin
      check("sat_hi", got_q[0], {1'b1, 16'hffff});
      check("sat_after", got_q[1], 4095);
      check("sat_lo", got_q[4], {1'b1, 16'h0000});
      check("sat_zero", got_q[5], 0);
    end

    // Reset mid-flush aborts it and restores k=1, l=1, M=0.
    load(2, 4, 7, 200);
    idle(10);
    check("mid_flush_busy", cfg_busy, 1);
    reset = 1'b0;
    drive(0, 0, 0);
    reset = 1'b1;
    check("rf_busy", cfg_busy, 0);
    check("rf_valid", out_valid, 0);
    check("rf_err", cfg_err, 0);
    got_q.delete();
    for (int i = 0; i < 4; i++) drive(1, 10);
    idle(6);
    check("dflt_count", got_q.size(), 4);
    if (got_q.size() >= 4) begin
      check("dflt0", got_q[0], 10);
      check("dflt3", got_q[3], 10);
    end
    drive(1, 30);
    drive(1, 30);
    reset = 1'b0;
    drive(0, 0, 0);
    reset = 1'b1;
    check("rs_valid", out_valid, 0);
    check("rs_data", out_data, 0);
    idle(6);

`ifdef TRAP_SHAPER_PEAK_DETECT_EN
    // With k=l=1 and M=0 the output equals the input, so pulses are exact.
    load(1, 1, 0, 50);
    wait_idle();
    peak_ready = 1'b0;
    foreach (pulse_a[i]) drive(1, pulse_a[i]);
    idle(6);
    check("pk_valid", peak_valid, 1);
    check("pk_data", peak_data, 120);
    check("pk_state", int'(peak_state), 2);
    lost_cnt = 0;
    foreach (pulse_b[i]) drive(1, pulse_b[i]);
    idle(6);
    check("pk_lost_cnt", lost_cnt, 1);
    check("pk_hold", peak_data, 120);
    check("pk_valid_hold", peak_valid, 1);
    peak_ready = 1'b1;
    drive(0, 0, 0);
    peak_ready = 1'b0;
    check("pk_done", peak_valid, 0);
    check("pk_idle", int'(peak_state), 0);
    drive(1, 0); drive(1, 60); drive(1, 10);
    idle(6);
    check("pk_report2", peak_valid, 1);
    reset = 1'b0;
    drive(0, 0, 0);
    reset = 1'b1;
    check("pk_rst_valid", peak_valid, 0);
    check("pk_rst_state", int'(peak_state), 0);
    check("pk_rst_data", peak_data, 0);
    idle(4);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
